// File: rtl/raytrace_job_dispatcher_pkg.sv
// Shared types for the scanline job dispatcher: colour word, dispatcher states, job x width.
package raytrace_job_dispatcher_pkg;
  localparam int PKG_COLOR_W = 12;
  localparam int JOB_X_W     = 10;

  typedef logic [PKG_COLOR_W-1:0] Color;

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} DispatchState;
endpackage

// File: rtl/raytrace_job_dispatcher_rr_arbiter.sv
// Round-robin arbiter: search starts at a registered pointer that moves past the winner on adv.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N-1:0]                     req,
  input  logic                             adv,
  output logic [N-1:0]                     gnt,
  output logic [$clog2(N > 1 ? N : 2)-1:0] idx
);
  localparam int IW = $clog2(N > 1 ? N : 2);

  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin
    int   j;
    logic found;
    j     = 0;
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

  assign ptr_d = (int'(idx) == N - 1) ? '0 : idx + IW'(1);

  always_ff @(posedge clk) begin
    if (rst)      ptr_q <= '0;
    else if (adv) ptr_q <= ptr_d;
  end
endmodule

// File: rtl/raytrace_job_dispatcher.sv
// Issues one scanline of pixel jobs to a worker pool (round-robin) and writes returned colours
// into the line buffer one per cycle, registered.
module raytrace_job_dispatcher
  import raytrace_job_dispatcher_pkg::*;
#(
  parameter int N_WORKERS   = 20,
  parameter int LINE_PIXELS = 640,
  parameter int X_W         = JOB_X_W,
  parameter int Y_W         = 12,
  parameter int COLOR_W     = PKG_COLOR_W
) (
  input  logic                         CLK100MHZ,
  input  logic                         ck_rst,
  input  logic                         line_start,
  input  logic [Y_W-1:0]               line_y,
  output logic                         busy,
  output logic                         line_done,
  input  logic [N_WORKERS-1:0]         job_req,
  output logic [N_WORKERS-1:0]         job_grant,
  output logic [X_W-1:0]               job_x,
  output logic [Y_W-1:0]               job_y,
  input  logic [N_WORKERS-1:0]         res_valid,
  input  logic [N_WORKERS*X_W-1:0]     res_x,
  input  logic [N_WORKERS*COLOR_W-1:0] res_color,
  output logic [N_WORKERS-1:0]         res_ready,
  output logic                         buf_we,
  output logic [X_W-1:0]               buf_addr,
  output logic [COLOR_W-1:0]           buf_data
);
  localparam int IW = $clog2(N_WORKERS > 1 ? N_WORKERS : 2);
  localparam int CW = X_W + 1;
  localparam logic [CW-1:0] LAST = CW'(LINE_PIXELS);

  DispatchState         state_q;
  logic [CW-1:0]        issue_q, issue_d, done_q, done_d;
  logic [Y_W-1:0]       job_y_q;
  logic                 busy_q, line_done_q, buf_we_q;
  logic [X_W-1:0]       buf_addr_q;
  logic [COLOR_W-1:0]   buf_data_q;

  logic                 job_en, res_en, job_fire, res_fire;
  logic [N_WORKERS-1:0] job_gnt, res_gnt;
  logic [IW-1:0]        job_idx, res_idx;

  // Arbiters are gated off during reset so grants never escape in the reset cycle.
  assign job_en   = !ck_rst && state_q == DISPATCH && issue_q != LAST;
  assign res_en   = !ck_rst && (state_q == DISPATCH || state_q == DRAIN) && done_q != LAST;
  assign job_fire = |job_gnt;
  assign res_fire = |res_gnt;
  assign issue_d  = issue_q + CW'(job_fire);
  assign done_d   = done_q + CW'(res_fire);

  rr_arbiter #(.N(N_WORKERS)) u_job_arb (
    .clk(CLK100MHZ), .rst(ck_rst), .req(job_req & {N_WORKERS{job_en}}),
    .adv(job_fire), .gnt(job_gnt), .idx(job_idx)
  );

  rr_arbiter #(.N(N_WORKERS)) u_res_arb (
    .clk(CLK100MHZ), .rst(ck_rst), .req(res_valid & {N_WORKERS{res_en}}),
    .adv(res_fire), .gnt(res_gnt), .idx(res_idx)
  );

  always_ff @(posedge CLK100MHZ) begin
    if (ck_rst) begin
      state_q     <= IDLE;
      issue_q     <= '0;
      done_q      <= '0;
      job_y_q     <= '0;
      busy_q      <= 1'b0;
      line_done_q <= 1'b0;
      buf_we_q    <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_we_q    <= res_fire;
      line_done_q <= 1'b0;
      issue_q     <= issue_d;
      done_q      <= done_d;
      if (res_fire) begin
        buf_addr_q <= res_x[res_idx*X_W +: X_W];
        buf_data_q <= res_color[res_idx*COLOR_W +: COLOR_W];
      end
      case (state_q)
        IDLE: if (line_start) begin
          job_y_q <= line_y;
          issue_q <= '0;
          done_q  <= '0;
          busy_q  <= 1'b1;
          state_q <= DISPATCH;
        end
        DISPATCH: if (issue_q == LAST) state_q <= DRAIN;
        DRAIN: if (done_q == LAST) begin
          state_q     <= DONE;
          line_done_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign line_done = line_done_q;
  assign job_grant = job_gnt;
  assign res_ready = res_gnt;
  assign job_x     = issue_q[X_W-1:0];
  assign job_y     = job_y_q;
  assign buf_we    = buf_we_q;
  assign buf_addr  = buf_addr_q;
  assign buf_data  = buf_data_q;
endmodule
